regfile_reader: RTL and testbench

Register file with two registered read ports and one write port for the pipelined ARM datapath. It sits between decode and the ID/EX boundary. Architectural registers are written from writeback. Read operands are captured on the clock edge and held, advanced or cleared under pipeline control (stall/flush). Same-cycle write-to-read bypass guarantees a read issued in the writeback cycle returns the new value.

---
 rtl/regfile_reader.sv | 47 ++++
 tb/tb_regfile_reader.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// regfile_reader: register file with two registered read ports, one write port, write-to-read bypass and stall/flush control
module regfile_reader #(
  parameter int N    = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd,
  input  logic          re,
  input  logic          flush,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          rd_valid
);
  logic [N-1:0] mem [NREG-1];
  logic [N-1:0] nxt1, nxt2;
  // Operand selection: XZR and out-of-range addresses read zero, then same-edge write bypass, then storage
  always_comb begin
    nxt1 = (int'(ra1) >= NREG-1) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    nxt2 = (int'(ra2) >= NREG-1) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
  end
  // Architectural state update from writeback; XZR and out-of-range writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG-1; i++) mem[i] <= '0;
    end else if (we && int'(wa) < NREG-1) begin
      mem[wa] <= wd;
    end
  end
  // Operand capture: flush inserts a bubble, re advances, otherwise hold for stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      rd1      <= '0;
      rd2      <= '0;
      rd_valid <= 1'b0;
    end else if (re) begin
      rd1      <= nxt1;
      rd2      <= nxt2;
      rd_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: directed scoreboard bench for regfile_reader
module tb_regfile_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0, flush = 1'b0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [63:0] wd = '0;
  logic [63:0] rd1, rd2;
  logic        rd_valid;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [63:0] r1;
    logic [63:0] r2;
    logic        v;
  } exp_t;
  exp_t q [$];

  regfile_reader #(.N(64), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re), .flush(flush),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Monitor: after every edge, compare the DUT outputs with the oldest queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (rd1 !== e.r1 || rd2 !== e.r2 || rd_valid !== e.v) begin
        errors++;
        $display("FAIL cycle_check @%0t: got rd1=%h rd2=%h v=%b expected rd1=%h rd2=%h v=%b",
                 $time, rd1, rd2, rd_valid, e.r1, e.r2, e.v);
      end
    end
  end

  task automatic cyc(input logic w, input logic [4:0] a, input logic [63:0] d,
                     input logic r, input logic f, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [63:0] e1, input logic [63:0] e2, input logic ev);
    exp_t e;
    @(negedge clk);
    we = w; wa = a; wd = d; re = r; flush = f; ra1 = a1; ra2 = a2;
    e.r1 = e1; e.r2 = e2; e.v = ev;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  localparam logic [63:0] A = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] B = 64'h0000_0000_B0B0_B0B0;

  initial begin
    #12;
    chk("reset_rd1", rd1, 64'h0);
    chk("reset_valid", {63'h0, rd_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    //  we  wa     wd                       re    fl    ra1    ra2    exp rd1          exp rd2 v
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd3,  5'd0,  64'h0,           64'h0,  1'b1);
    cyc(1'b1, 5'd5,  A,                     1'b0, 1'b0, 5'd5,  5'd0,  64'h0,           64'h0,  1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd5,  5'd0,  A,               64'h0,  1'b1);
    cyc(1'b1, 5'd7,  64'h1234,              1'b1, 1'b0, 5'd7,  5'd7,  64'h1234,        64'h1234, 1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd7,  5'd5,  64'h1234,        A,      1'b1);
    cyc(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 5'd31, 5'd31, 64'h0,         64'h0,  1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd31, 5'd5,  64'h0,           A,      1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd5,  5'd7,  A,               64'h1234, 1'b1);
    cyc(1'b1, 5'd5,  B,                     1'b0, 1'b0, 5'd5,  5'd7,  A,               64'h1234, 1'b1);
    cyc(1'b1, 5'd5,  B,                     1'b0, 1'b0, 5'd5,  5'd7,  A,               64'h1234, 1'b1);
    cyc(1'b1, 5'd5,  B,                     1'b0, 1'b0, 5'd5,  5'd7,  A,               64'h1234, 1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd5,  5'd7,  B,               64'h1234, 1'b1);
    cyc(1'b1, 5'd3,  64'h33,                1'b1, 1'b1, 5'd5,  5'd7,  64'h0,           64'h0,  1'b0);
    cyc(1'b0, 5'd0,  64'h0,                 1'b0, 1'b0, 5'd5,  5'd7,  64'h0,           64'h0,  1'b0);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd3,  5'd0,  64'h33,          64'h0,  1'b1);
    cyc(1'b1, 5'd1,  64'h11,                1'b0, 1'b0, 5'd3,  5'd0,  64'h33,          64'h0,  1'b1);
    cyc(1'b1, 5'd2,  64'h22,                1'b0, 1'b0, 5'd3,  5'd0,  64'h33,          64'h0,  1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd2,  5'd1,  64'h22,          64'h11, 1'b1);
    cyc(1'b1, 5'd4,  64'h44,                1'b1, 1'b0, 5'd4,  5'd2,  64'h44,          64'h22, 1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd2,  5'd3,  64'h22,          64'h33, 1'b1);
    @(negedge clk);
    re = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rd1", rd1, 64'h0);
    chk("async_rst_rd2", rd2, 64'h0);
    chk("async_rst_valid", {63'h0, rd_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 5'd6,  64'h66,                1'b1, 1'b0, 5'd6,  5'd3,  64'h66,          64'h0,  1'b1);
    cyc(1'b0, 5'd0,  64'h0,                 1'b1, 1'b0, 5'd2,  5'd6,  64'h0,           64'h66, 1'b1);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
endmodule
